// File: rtl/ro_pair_compare.sv
// Ring-oscillator pair selector and frequency comparator: two N:1 selectors feed
// synchronised edge counters over a programmable window, yielding one PUF response bit.
module ro_pair_compare #(
   parameter int SEL_W = 4,
   parameter int CNT_W = 16,
   parameter int WIN_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2**SEL_W-1:0] ro_in,
   input  logic                start,
   input  logic [SEL_W-1:0]    sel_a,
   input  logic [SEL_W-1:0]    sel_b,
   input  logic [WIN_W-1:0]    win_len,
   output logic                busy,
   output logic                done,
   output logic                resp,
   output logic [CNT_W-1:0]    cnt_a,
   output logic [CNT_W-1:0]    cnt_b,
   output logic                overflow
);

   typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

   state_t           r_state;
   state_t           w_stateNext;
   logic             w_accept;
   logic             w_counting;
   logic             w_finish;

   logic [SEL_W-1:0] r_selA;
   logic [SEL_W-1:0] r_selB;
   logic [WIN_W-1:0] r_winLeft;
   logic [1:0]       r_settleCnt;
   logic [2:0]       r_syncA;
   logic [2:0]       r_syncB;
   logic [CNT_W-1:0] r_cntA;
   logic [CNT_W-1:0] r_cntB;
   logic             r_overflow;
   logic             r_resp;
   logic             r_done;

   logic             w_edgeA;
   logic             w_edgeB;
   logic             w_satA;
   logic             w_satB;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      w_accept    = 1'b0;
      w_counting  = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_stateNext = SETTLE;
            end
         end
         SETTLE: begin
            if (r_settleCnt == 2'd3) w_stateNext = COUNT;
         end
         COUNT: begin
            w_counting = 1'b1;
            if (r_winLeft <= WIN_W'(1)) w_stateNext = DONE;
         end
         DONE: begin
            w_finish    = 1'b1;
            w_stateNext = IDLE;
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // Bit 0 and 1 form the synchroniser, bit 2 holds the previous sample for edge detection
   assign w_edgeA = r_syncA[1] & ~r_syncA[2];
   assign w_edgeB = r_syncB[1] & ~r_syncB[2];
   assign w_satA  = w_counting & w_edgeA & (r_cntA == {CNT_W{1'b1}});
   assign w_satB  = w_counting & w_edgeB & (r_cntB == {CNT_W{1'b1}});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_selA      <= '0;
         r_selB      <= '0;
         r_winLeft   <= '0;
         r_settleCnt <= '0;
         r_syncA     <= '0;
         r_syncB     <= '0;
         r_cntA      <= '0;
         r_cntB      <= '0;
         r_overflow  <= 1'b0;
         r_resp      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_syncA <= {r_syncA[1:0], ro_in[r_selA]};
         r_syncB <= {r_syncB[1:0], ro_in[r_selB]};
         r_done  <= w_finish;

         if (w_accept) begin
            r_selA      <= sel_a;
            r_selB      <= sel_b;
            r_winLeft   <= (win_len == '0) ? WIN_W'(1) : win_len;
            r_settleCnt <= '0;
            r_cntA      <= '0;
            r_cntB      <= '0;
            r_overflow  <= 1'b0;
         end

         if (r_state == SETTLE) r_settleCnt <= r_settleCnt + 2'd1;

         // Counters stick at all-ones; a lost edge at that point marks overflow
         if (w_counting) begin
            r_winLeft <= r_winLeft - WIN_W'(1);
            if (w_edgeA && !w_satA) r_cntA <= r_cntA + CNT_W'(1);
            if (w_edgeB && !w_satB) r_cntB <= r_cntB + CNT_W'(1);
            if (w_satA || w_satB) r_overflow <= 1'b1;
         end

         if (w_finish) r_resp <= (r_cntA > r_cntB);
      end
   end

   assign busy     = (r_state != IDLE);
   assign done     = r_done;
   assign resp     = r_resp;
   assign cnt_a    = r_cntA;
   assign cnt_b    = r_cntB;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_ro_pair_compare.sv
// Directed bench for ro_pair_compare: a vector table of challenges plus hand-written
// sequences for saturation, busy-time starts, back-to-back starts and mid-count reset.
module tb_ro_pair_compare;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] ro_in = '0;
   logic        start0, start1;
   logic [3:0]  sel_a, sel_b;
   logic [15:0] win_len;

   logic        busy0, done0, resp0, ovf0;
   logic [15:0] cntA0, cntB0;
   logic        busy1, done1, resp1, ovf1;
   logic [3:0]  cntA1, cntB1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ro_pair_compare #(.SEL_W(4), .CNT_W(16), .WIN_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start0),
      .sel_a(sel_a), .sel_b(sel_b), .win_len(win_len),
      .busy(busy0), .done(done0), .resp(resp0),
      .cnt_a(cntA0), .cnt_b(cntB0), .overflow(ovf0)
   );

   ro_pair_compare #(.SEL_W(4), .CNT_W(4), .WIN_W(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start1),
      .sel_a(sel_a), .sel_b(sel_b), .win_len(win_len),
      .busy(busy1), .done(done1), .resp(resp1),
      .cnt_a(cntA1), .cnt_b(cntB1), .overflow(ovf1)
   );

   // Oscillators: [1] stuck high, [3] /8, [5] /4, [9] /12, [15] /6, the rest stuck low
   initial begin
      int phase;
      logic [15:0] roVec;
      phase = 0;
      forever begin
         @(negedge clk);
         phase++;
         roVec     = '0;
         roVec[1]  = 1'b1;
         roVec[3]  = ((phase / 4) % 2) == 1;
         roVec[5]  = ((phase / 2) % 2) == 1;
         roVec[9]  = ((phase / 6) % 2) == 1;
         roVec[15] = ((phase / 3) % 2) == 1;
         ro_in     = roVec;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic checkRange(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
      end
   endtask

   // Pulses start on DUT d, then watches it for W+9 cycles; optionally pokes start and the challenge mid-run
   task automatic applyStimulus(input int d, input int sA, input int sB, input int win,
                                input int midStartLat, input int doneStartLat, input int chgLat,
                                output int doneLat, output int busyCyc, output int donePulses);
      int w;
      logic b, dn;
      w          = (win == 0) ? 1 : win;
      doneLat    = -1;
      busyCyc    = 0;
      donePulses = 0;
      sel_a   = 4'(sA);
      sel_b   = 4'(sB);
      win_len = 16'(win);
      if (d == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      for (int lat = 0; lat < w + 9; lat++) begin
         if (d == 0) begin b = busy0; dn = done0; end
         else        begin b = busy1; dn = done1; end
         if (b) busyCyc++;
         if (dn) begin
            donePulses++;
            if (doneLat < 0) doneLat = lat;
         end
         if (lat == midStartLat || lat == doneStartLat) begin
            if (d == 0) start0 = 1'b1; else start1 = 1'b1;
         end else begin
            start0 = 1'b0;
            start1 = 1'b0;
         end
         if (lat == chgLat) begin
            sel_a   = 4'(sB);
            win_len = 16'd5;
         end
         @(negedge clk);
      end
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   typedef struct {
      string name;
      int    selA;
      int    selB;
      int    win;
      int    aLo, aHi, bLo, bHi;
      logic  resp;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int doneLat, busyCyc, donePulses, w, lat, pulses;

      vecs[0] = '{"basic",   3, 9, 120, 14, 16,  9, 11, 1'b1};
      vecs[1] = '{"swap",    9, 3, 120,  9, 11, 14, 16, 1'b0};
      vecs[2] = '{"tie",     3, 3, 120, 14, 16, 14, 16, 1'b0};
      vecs[3] = '{"topSel", 15, 3, 120, 19, 21, 14, 16, 1'b1};
      vecs[4] = '{"quietA",  0, 9,  60,  0,  0,  4,  6, 1'b0};
      vecs[5] = '{"winZero", 1, 0,   0,  0,  0,  0,  0, 1'b0};

      rst_n   = 1'b0;
      start0  = 1'b0;
      start1  = 1'b0;
      sel_a   = '0;
      sel_b   = '0;
      win_len = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("idleOutputs", {busy0, done0, resp0, cntA0, cntB0, ovf0}, 64'd0);
      end

      for (int i = 0; i < 6; i++) begin
         w = (vecs[i].win == 0) ? 1 : vecs[i].win;
         applyStimulus(0, vecs[i].selA, vecs[i].selB, vecs[i].win, -1, -1, -1,
                       doneLat, busyCyc, donePulses);
         checkOutput({vecs[i].name, "_latency"}, 64'(doneLat), 64'(w + 5));
         checkOutput({vecs[i].name, "_busyCycles"}, 64'(busyCyc), 64'(w + 5));
         checkOutput({vecs[i].name, "_donePulses"}, 64'(donePulses), 64'd1);
         checkRange({vecs[i].name, "_cntA"}, int'(cntA0), vecs[i].aLo, vecs[i].aHi);
         checkRange({vecs[i].name, "_cntB"}, int'(cntB0), vecs[i].bLo, vecs[i].bHi);
         checkOutput({vecs[i].name, "_resp"}, 64'(resp0), 64'(vecs[i].resp));
         checkOutput({vecs[i].name, "_overflow"}, 64'(ovf0), 64'd0);
         if (vecs[i].selA == vecs[i].selB)
            checkOutput({vecs[i].name, "_equalCounts"}, 64'(cntA0), 64'(cntB0));
      end

      // Start mid-COUNT and on the DONE cycle, challenge changed mid-COUNT: all ignored
      applyStimulus(0, 3, 9, 120, 60, 124, 70, doneLat, busyCyc, donePulses);
      checkOutput("busyStart_latency", 64'(doneLat), 64'd125);
      checkOutput("busyStart_busyCycles", 64'(busyCyc), 64'd125);
      checkOutput("busyStart_donePulses", 64'(donePulses), 64'd1);
      checkRange("busyStart_cntA", int'(cntA0), 14, 16);
      checkRange("busyStart_cntB", int'(cntB0), 9, 11);
      checkOutput("busyStart_resp", 64'(resp0), 64'd1);

      // A start raised while done=1 is accepted at the following edge
      sel_a   = 4'd3;
      sel_b   = 4'd9;
      win_len = 16'd10;
      start0  = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      lat = 0;
      while (!done0 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("b2b_firstDone", 64'(done0), 64'd1);
      win_len = 16'd80;
      start0  = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      checkOutput("b2b_acceptedBusy", 64'(busy0), 64'd1);
      checkOutput("b2b_countsCleared", {cntA0, cntB0}, 64'd0);
      lat = 0;
      while (!done0 && lat < 120) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("b2b_latency", 64'(lat), 64'd85);
      checkRange("b2b_cntA", int'(cntA0), 9, 11);
      checkRange("b2b_cntB", int'(cntB0), 6, 7);
      checkOutput("b2b_resp", 64'(resp0), 64'd1);
      repeat (2) @(negedge clk);

      // Saturation on the 4-bit instance
      applyStimulus(1, 5, 0, 100, -1, -1, -1, doneLat, busyCyc, donePulses);
      checkOutput("sat_latency", 64'(doneLat), 64'd105);
      checkOutput("sat_cntA", 64'(cntA1), 64'd15);
      checkOutput("sat_cntB", 64'(cntB1), 64'd0);
      checkOutput("sat_overflow", 64'(ovf1), 64'd1);
      checkOutput("sat_resp", 64'(resp1), 64'd1);
      repeat (10) @(negedge clk);
      checkOutput("sat_heldCnt", 64'(cntA1), 64'd15);
      checkOutput("sat_heldOverflow", 64'(ovf1), 64'd1);
      sel_a   = 4'd0;
      sel_b   = 4'd0;
      win_len = 16'd10;
      start1  = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      checkOutput("sat_clearedOverflow", 64'(ovf1), 64'd0);
      checkOutput("sat_clearedCnt", 64'(cntA1), 64'd0);
      lat = 0;
      while (!done1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("sat_quietDone", 64'(done1), 64'd1);
      checkOutput("sat_quietOverflow", 64'(ovf1), 64'd0);
      repeat (2) @(negedge clk);

      // Reset pulse mid-COUNT aborts with no done pulse
      sel_a   = 4'd3;
      sel_b   = 4'd9;
      win_len = 16'd120;
      start0  = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (60) @(negedge clk);
      checkOutput("rstMid_busyBefore", 64'(busy0), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("rstMid_outputs", {busy0, done0, resp0, cntA0, cntB0, ovf0}, 64'd0);
      pulses = 0;
      for (int i = 0; i < 140; i++) begin
         @(negedge clk);
         if (done0) pulses++;
      end
      checkOutput("rstMid_noDone", 64'(pulses), 64'd0);
      applyStimulus(0, 3, 9, 120, -1, -1, -1, doneLat, busyCyc, donePulses);
      checkOutput("rstMid_afterLatency", 64'(doneLat), 64'd125);
      checkRange("rstMid_afterCntA", int'(cntA0), 14, 16);
      checkRange("rstMid_afterCntB", int'(cntB0), 9, 11);
      checkOutput("rstMid_afterResp", 64'(resp0), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
